// File: rtl/player_enc.sv
// Forward PRESENT pLayer: serial bit permutation engine.
// A captured 64-bit state is scattered BITS_PER_CYCLE bits per clock into a
// work register; the finished word is published to permuted in one step.
module player_enc #(
    parameter int unsigned SIZE           = 64,
    parameter int unsigned BITS_PER_CYCLE = 4
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            start,
    input  logic [SIZE-1:0] original,
    output logic [SIZE-1:0] permuted,
    output logic            busy,
    output logic            done
);

    localparam int unsigned IDX_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  index;
    logic [SIZE-1:0]   source;
    logic [SIZE-1:0]   work;
    logic [SIZE-1:0]   work_next;
    logic              load;
    logic              step;
    logic              last;

    // Destination of source bit i; the top bit maps onto itself.
    function automatic int unsigned p_pos(input int unsigned i);
        if (i == SIZE - 1) begin
            return SIZE - 1;
        end
        return (16 * i) % (SIZE - 1);
    endfunction

    // Final group is the one that brings the index up to SIZE.
    assign last = ((index + IDX_W'(BITS_PER_CYCLE)) == IDX_W'(SIZE));

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only honoured outside RUN.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: state_next = start ? RUN : IDLE;
            RUN:        if (last) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // Datapath control decoded from the current state.
    always_comb begin
        load = 1'b0;
        step = 1'b0;
        case (state)
            IDLE, DONE: load = start;
            RUN:        step = 1'b1;
            default:    ;
        endcase
    end

    // Scatter the current group of source bits into their permuted slots.
    always_comb begin
        work_next = work;
        for (int unsigned i = 0; i < SIZE; i++) begin
            if ((IDX_W'(i) >= index) &&
                (IDX_W'(i) < (index + IDX_W'(BITS_PER_CYCLE)))) begin
                work_next[p_pos(i)] = source[i];
            end
        end
    end

    // Source capture, group stepping and atomic publish of the result.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            index    <= '0;
            source   <= '0;
            work     <= '0;
            permuted <= '0;
        end else if (load) begin
            source <= original;
            index  <= '0;
            work   <= '0;
        end else if (step) begin
            work  <= work_next;
            index <= index + IDX_W'(BITS_PER_CYCLE);
            if (last) begin
                permuted <= work_next;
            end
        end
    end

    // Status flags registered from the next state so they track RUN/DONE exactly.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_player_enc.sv
// Bench for player_enc: directed table, back-to-back, reset abort and random
// runs on three instances (1, 4 and 16 bits per cycle) with a scoreboard.
module tb_player_enc;

    logic             Clock;
    logic             Reset;
    logic      [63:0] original;
    logic      [2:0]  start_v;
    logic [2:0][63:0] perm;
    logic      [2:0]  busy;
    logic      [2:0]  done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          inst;
        logic [63:0] orig;
        logic [63:0] exp;
        int          start_cyc;
    } sb_t;

    typedef struct {
        logic [63:0] orig;
        logic [63:0] exp;
    } vec_t;

    sb_t  sb[$];
    sb_t  mon_rec;
    vec_t vecs[6];

    player_enc #(.SIZE(64), .BITS_PER_CYCLE(4)) u_b4 (
        .Clock(Clock), .Reset(Reset), .start(start_v[0]), .original(original),
        .permuted(perm[0]), .busy(busy[0]), .done(done[0]));

    player_enc #(.SIZE(64), .BITS_PER_CYCLE(1)) u_b1 (
        .Clock(Clock), .Reset(Reset), .start(start_v[1]), .original(original),
        .permuted(perm[1]), .busy(busy[1]), .done(done[1]));

    player_enc #(.SIZE(64), .BITS_PER_CYCLE(16)) u_b16 (
        .Clock(Clock), .Reset(Reset), .start(start_v[2]), .original(original),
        .permuted(perm[2]), .busy(busy[2]), .done(done[2]));

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // Reference forward pLayer in the classic nibble-lane form.
    function automatic logic [63:0] fwd_model(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) r[(i / 4) + 16 * (i % 4)] = x[i];
        return r;
    endfunction

    // Existing decryption pLayer (inverse permutation).
    function automatic logic [63:0] inv_player(input logic [63:0] y);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < 64; j++) r[(j / 16) + 4 * (j % 16)] = y[j];
        return r;
    endfunction

    function automatic int lat_of(input int k);
        if (k == 1) return 64;
        if (k == 2) return 4;
        return 16;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every done must match the oldest pending operation.
    always @(negedge Clock) begin
        for (int k = 0; k < 3; k++) begin
            if (done[k] === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done inst=%0d actual=1 required=0 t=%0t", k, $time);
                end else begin
                    mon_rec = sb.pop_front();
                    chk("done_inst", 64'(k), 64'(mon_rec.inst));
                    chk("permuted", perm[k], mon_rec.exp);
                    chk("latency", 64'(cyc - mon_rec.start_cyc), 64'(lat_of(k)));
                    chk("busy_at_done", 64'(busy[k]), 64'd0);
                    chk("inverse_roundtrip", inv_player(perm[k]), mon_rec.orig);
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (sb.size() != 0 && c < budget) begin
            @(negedge Clock); #1;
            c++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    // One operation: start for one cycle, scramble original mid-run, await done.
    task automatic run_op(input int k, input logic [63:0] val, input logic [63:0] exp);
        sb_t r;
        original   = val;
        start_v[k] = 1'b1;
        r.inst      = k;
        r.orig      = val;
        r.exp       = exp;
        r.start_cyc = cyc + 1;
        sb.push_back(r);
        @(negedge Clock); #1;
        start_v[k] = 1'b0;
        original   = {$urandom, $urandom};
        chk("busy_in_run", 64'(busy[k]), 64'd1);
        wait_idle(200);
        @(negedge Clock); #1;
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        sb_t         r;

        vecs[0] = '{64'h0000000000000002, 64'h0000000000010000};
        vecs[1] = '{64'h000000000000000F, 64'h0001000100010001};
        vecs[2] = '{64'h0000000000000010, 64'h0000000000000002};
        vecs[3] = '{64'h8000000000000001, 64'h8000000000000001};
        vecs[4] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
        vecs[5] = '{64'h0000000000000000, 64'h0000000000000000};

        Reset    = 1'b1;
        start_v  = '0;
        original = '0;
        repeat (3) @(negedge Clock);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_permuted", perm[k], 64'd0);
            chk("reset_busy", 64'(busy[k]), 64'd0);
            chk("reset_done", 64'(done[k]), 64'd0);
        end
        Reset = 1'b0;
        @(negedge Clock); #1;

        // Directed table on the default configuration.
        for (int v = 0; v < 6; v++) run_op(0, vecs[v].orig, vecs[v].exp);

        // Start held high across two operations: done every 17 cycles.
        a = 64'h0123456789ABCDEF;
        b = 64'hFEDCBA9876543210;
        original   = a;
        start_v[0] = 1'b1;
        r = '{0, a, fwd_model(a), cyc + 1};
        sb.push_back(r);
        r = '{0, b, fwd_model(b), cyc + 1 + 17};
        sb.push_back(r);
        @(negedge Clock); #1;
        original = b;
        chk("busy_held_start", 64'(busy[0]), 64'd1);
        wait_idle(100);
        start_v[0] = 1'b0;
        @(negedge Clock); #1;
        chk("idle_after_held", 64'(busy[0]), 64'd0);

        for (int n = 0; n < 20; n++) begin
            a = {$urandom, $urandom};
            run_op(0, a, fwd_model(a));
        end

        // Reset in the middle of RUN aborts the operation with no done.
        original   = 64'hA5A5A5A5A5A5A5A5;
        start_v[0] = 1'b1;
        @(negedge Clock); #1;
        start_v[0] = 1'b0;
        repeat (7) @(negedge Clock);
        #1;
        chk("busy_before_abort", 64'(busy[0]), 64'd1);
        Reset = 1'b1;
        @(negedge Clock); #1;
        chk("abort_permuted", perm[0], 64'd0);
        chk("abort_busy", 64'(busy[0]), 64'd0);
        chk("abort_done", 64'(done[0]), 64'd0);
        Reset = 1'b0;
        repeat (30) @(negedge Clock);
        #1;
        chk("post_abort_busy", 64'(busy[0]), 64'd0);
        chk("post_abort_permuted", perm[0], 64'd0);

        // First start after reset is accepted normally.
        run_op(0, vecs[0].orig, vecs[0].exp);

        // One bit per cycle.
        for (int v = 0; v < 6; v++) run_op(1, vecs[v].orig, vecs[v].exp);
        for (int n = 0; n < 3; n++) begin
            a = {$urandom, $urandom};
            run_op(1, a, fwd_model(a));
        end

        // Sixteen bits per cycle.
        for (int v = 0; v < 6; v++) run_op(2, vecs[v].orig, vecs[v].exp);
        for (int n = 0; n < 10; n++) begin
            a = {$urandom, $urandom};
            run_op(2, a, fwd_model(a));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
